dpram_be: RTL
=============

DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 SHALL have parameter INIT_FILE, default "", hex memory image loaded at elaboration; empty string means contents are undefined.
REQ-002 SHALL have parameter DP, default 512, depth in words.
REQ-003 SHALL have parameter DW, default 32, word width; DW SHALL be a multiple of BW.
REQ-004 SHALL have parameter BW, default 8, byte-lane width; NB = DW/BW lanes.
REQ-005 SHALL have parameter AW, default $clog2(DP), address width.
REQ-006 SHALL have parameter RD_MODE, default 0, same-port read-during-write mode: 0 read-first, 1 write-first, 2 no-change.
REQ-007 SHALL have parameter OUT_REG, default 0, adds one output pipeline stage when 1.
REQ-008 Port list: one clock; reset is asynchronous and active-high.
REQ-009 clk  in  1  sole clock; all logic on rising edge.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 cea / ceb  in  1  port A / port B access enable.
REQ-012 wea / web  in  NB  port A / port B byte write enables; any bit set means write, all zero means read.
REQ-013 addra / addrb  in  AW  port A / port B word address.
REQ-014 dina / dinb  in  DW  port A / port B write data.
REQ-015 douta / doutb  out  DW  port A / port B read data.
REQ-016 clr  in  1  single-cycle request to zero the whole array.
REQ-017 busy  out  1  high while the clear sequence runs.
REQ-018 coll  out  1  one-cycle pulse flagging an address collision.

Function
REQ-019 A read (ce=1, we=0) SHALL present ram[addr] on dout 1 cycle after the access edge when OUT_REG=0, and 2 cycles after when OUT_REG=1.
REQ-020 dout SHALL hold its value in every cycle with no read completing.
REQ-021 A write SHALL update only the byte lanes whose we bit is set.
REQ-022 Same-port write output:
- RD_MODE=0: dout returns the pre-write word.
- RD_MODE=1: dout returns the post-write merged word.
- RD_MODE=2: dout holds its previous value.
REQ-023 Both ports writing the same address: lanes set in wea SHALL take dina; lanes set only in web SHALL take dinb.
REQ-024 Cross-port read of an address being written in the same cycle SHALL return the pre-write word, regardless of RD_MODE.
REQ-025 coll SHALL pulse 1 cycle after any edge where cea=ceb=1, addra==addrb, and at least one port writes.
REQ-026 Clear FSM states:
- IDLE -> CLEAR on clr=1.
- CLEAR writes zero to address counter 0..DP-1, one word per cycle.
- CLEAR -> IDLE after address DP-1 is written.
REQ-027 busy SHALL be 1 from the cycle after clr through the last clear write; the whole sequence takes exactly DP cycles.
REQ-028 While busy=1, all external port accesses SHALL be ignored: no writes, dout held, coll=0.
REQ-029 clr asserted while busy SHALL be ignored.
REQ-030 clr asserted together with a port access in IDLE SHALL let the access complete in that cycle; clearing starts next cycle.

Reset
REQ-031 rst SHALL asynchronously force douta, doutb, and the OUT_REG stage to zero.
REQ-032 rst SHALL asynchronously force busy=0, coll=0, FSM=IDLE, and the clear counter to 0.
REQ-033 rst SHALL NOT alter array contents.
REQ-034 rst during CLEAR SHALL abort the sequence; already-cleared words stay zero and the rest are unchanged.

Structure
REQ-035 RD_MODE encodings and the FSM state constants SHALL live in shared package mem_pkg.
REQ-036 The clear sequencer SHALL be sub-module mem_clr_seq, which outputs busy, the clear address, and the clear write strobe.
REQ-037 The array SHALL be a single reg array coded for block-RAM inference, with per-lane write loops.

Verification
REQ-038 DW=32, OUT_REG=0: write A 0x11223344 to addr 5 (wea=0xF), read addr 5 on B next cycle -> doutb=0x11223344 one cycle later.
REQ-039 RD_MODE=1: A holds 0xAAAAAAAA at addr 3, write wea=0x3 dina=0x00005555 -> douta=0xAAAA5555 the same cycle the write lands.
REQ-040 Same-edge writes to addr 7, wea=0xC dina=0x12340000, web=0xF dinb=0x0000ABCD -> ram[7]=0x1234ABCD and coll=1 for exactly one cycle.
REQ-041 OUT_REG=1: read addr 9 holding 0xDEADBEEF -> douta=0xDEADBEEF two cycles after the access edge.
REQ-042 DP=16: pulse clr -> busy high 16 cycles; all addresses then read 0; writes issued while busy are lost.
REQ-043 Assert rst at cycle 5 of a clear -> busy=0 and douta=0 immediately; addr 0-4 read 0 and addr 5-15 keep prior data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the byte-enable dual-port RAM: read-during-write modes
// and the clear sequencer state encoding.
package mem_pkg;

  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;
  localparam int NO_CHANGE = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/dpram_be_if.sv
// Bus bundle for dpram_be: both access ports plus the clear request/status lines.
interface dpram_be_if #(
  parameter int DW = 32,
  parameter int NB = 4,
  parameter int AW = 9
);
  logic          cea;
  logic          ceb;
  logic [NB-1:0] wea;
  logic [NB-1:0] web;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dina;
  logic [DW-1:0] dinb;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;
  logic          clr;
  logic          busy;
  logic          coll;

  modport master (
    output cea, ceb, wea, web, addra, addrb, dina, dinb, clr,
    input  douta, doutb, busy, coll
  );

  modport slave (
    input  cea, ceb, wea, web, addra, addrb, dina, dinb, clr,
    output douta, doutb, busy, coll
  );
endinterface

// File: rtl/mem_clr_seq.sv
// Clear sequencer: on a request in IDLE, walks the address counter 0..DP-1
// producing one zero-write strobe per cycle, then returns to IDLE.
module mem_clr_seq
  import mem_pkg::*;
#(
  parameter int DP = 512,
  parameter int AW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          clr_we_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // next-state and counter logic; requests arriving mid-clear are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte-lane write enables, selectable same-port
// read-during-write behaviour, optional output register and a bulk clear.
module dpram_be
  import mem_pkg::*;
#(
  parameter string INIT_FILE = "",
  parameter int    DP        = 512,
  parameter int    DW        = 32,
  parameter int    BW        = 8,
  parameter int    AW        = $clog2(DP),
  parameter int    RD_MODE   = 0,
  parameter int    OUT_REG   = 0
) (
  input logic       clk,
  input logic       rst,
  dpram_be_if.slave bus
);

  localparam int NB = DW / BW;

  logic [DW-1:0] ram [DP];

  logic          busy_s;
  logic [AW-1:0] clr_addr_s;
  logic          clr_we_s;
  logic          wr_a_s;
  logic          wr_b_s;
  logic          rd_a_s;
  logic          rd_b_s;
  logic [DW-1:0] rda_q;
  logic [DW-1:0] rdb_q;
  logic          vlda_q;
  logic          vldb_q;
  logic [DW-1:0] outa_q;
  logic [DW-1:0] outb_q;
  logic          coll_q;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
      else       r[i*BW +: BW] = old_w[i*BW +: BW];
    end
    return r;
  endfunction

  mem_clr_seq #(.DP(DP), .AW(AW)) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus.clr),
    .busy_o     (busy_s),
    .clr_addr_o (clr_addr_s),
    .clr_we_o   (clr_we_s)
  );

  // While clearing, the array belongs to the sequencer and the ports are dead.
  assign wr_a_s = bus.cea & ~busy_s & (|bus.wea);
  assign wr_b_s = bus.ceb & ~busy_s & (|bus.web);
  assign rd_a_s = bus.cea & ~busy_s & (~(|bus.wea) | (RD_MODE != NO_CHANGE));
  assign rd_b_s = bus.ceb & ~busy_s & (~(|bus.web) | (RD_MODE != NO_CHANGE));

  // array write port; A is applied last so it owns lanes both ports enable
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      ram[clr_addr_s] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b_s && bus.web[i]) ram[bus.addrb][i*BW +: BW] <= bus.dinb[i*BW +: BW];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a_s && bus.wea[i]) ram[bus.addra][i*BW +: BW] <= bus.dina[i*BW +: BW];
      end
    end
  end

  // read stage; only the same port's own lanes are merged in write-first mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rda_q  <= {DW{1'b0}};
      rdb_q  <= {DW{1'b0}};
      vlda_q <= 1'b0;
      vldb_q <= 1'b0;
    end else begin
      vlda_q <= rd_a_s;
      vldb_q <= rd_b_s;
      if (rd_a_s) begin
        rda_q <= (RD_MODE == WR_FIRST && wr_a_s) ?
                 lane_merge(ram[bus.addra], bus.dina, bus.wea) : ram[bus.addra];
      end
      if (rd_b_s) begin
        rdb_q <= (RD_MODE == WR_FIRST && wr_b_s) ?
                 lane_merge(ram[bus.addrb], bus.dinb, bus.web) : ram[bus.addrb];
      end
    end
  end

  // optional output stage and collision flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outa_q <= {DW{1'b0}};
      outb_q <= {DW{1'b0}};
      coll_q <= 1'b0;
    end else begin
      if (vlda_q) outa_q <= rda_q;
      if (vldb_q) outb_q <= rdb_q;
      coll_q <= bus.cea & bus.ceb & ~busy_s & (bus.addra == bus.addrb) &
                ((|bus.wea) | (|bus.web));
    end
  end

  assign bus.douta = (OUT_REG != 0) ? outa_q : rda_q;
  assign bus.doutb = (OUT_REG != 0) ? outb_q : rdb_q;
  assign bus.busy  = busy_s;
  assign bus.coll  = coll_q;

endmodule
